ff_shift_reg: RTL and testbench
===============================

# ff_shift_reg

Parametrised universal register built around the team's D flip-flop cell, WIDTH bits wide. Per clock it can hold, shift right, shift left or parallel-load, and it exposes true and complemented outputs (Q/Qbar). It also has a self-timed serialiser mode that shifts a loaded word out LSB-first, with busy/done status. It sits between the adder datapath and serial consumers, replacing ad-hoc chains of single-bit flip-flops.

## Interface
Parameters:
- WIDTH, 8: register width in bits; legal range 2..64.
- RESET_VAL, 0: value loaded into Q on reset; WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; asserting it forces reset values immediately.
- clr  input  1  synchronous clear; Q becomes 0 and any serialisation is aborted.
- en  input  1  clock enable for manual modes.
- mode  input  2  manual operation: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- D  input  WIDTH  parallel load data.
- sin_r  input  1  serial fill bit for right shifts; enters at the MSB.
- sin_l  input  1  serial fill bit for left shifts; enters at the LSB.
- start  input  1  begins serialisation of D.
- Q  output  WIDTH  register contents.
- Qbar  output  WIDTH  bitwise complement of Q, always.
- sout  output  1  serial output; equals Q[0] combinationally.
- busy  output  1  serialiser active.
- done  output  1  one-cycle pulse when serialisation completes.

## Operation
- Reset values: Q = RESET_VAL, Qbar = ~RESET_VAL, busy = 0, done = 0, internal bit counter = 0, state = IDLE.
- Priority at each rising edge: clr, then serialiser (start or BUSY), then manual mode.
- clr: sets Q = 0, state = IDLE, busy = 0 and counter = 0. done is not pulsed. en, mode and start are ignored that cycle.
- Manual operation (state IDLE, start = 0): applies only when en = 1; when en = 0, Q holds.
  - Shift right: Q = {sin_r, Q[WIDTH-1:1]}.
  - Shift left: Q = {Q[WIDTH-2:0], sin_l}.
  - Load: Q = D.
- State machine has two states, IDLE and BUSY.
  - IDLE, start = 1 (regardless of en and mode): Q = D, counter = 0, go to BUSY.
  - BUSY: each edge shifts Q right one place (fill rule in Configuration) and increments counter. On the edge where counter == WIDTH-1 the state returns to IDLE and done is set.
  - In BUSY, start, en, mode and D are ignored. Only clr and reset interrupt the sequence.
- done is registered: it is high exactly for the first IDLE cycle after BUSY and low otherwise.
- start in the same cycle that done is high: accepted, and a new load occurs. Back-to-back words are therefore separated by exactly one idle cycle.
- Counter width is $clog2(WIDTH) bits. It never wraps past WIDTH-1.

## Timing
- Manual ops have 1-cycle latency: the result is visible on Q/Qbar/sout after the edge.
- Serialiser: start is sampled at edge E0.
  - busy is high from E0 through E(WIDTH).
  - During busy cycle k (k = 0..WIDTH-1), sout = D[k].
  - done is high in the cycle after E(WIDTH).
  - Total occupancy is WIDTH cycles.
- Qbar and sout have no register of their own; they follow Q combinationally.
- reset mid-serialisation: outputs go to reset values immediately (asynchronously), with no done pulse. Release is synchronised by the caller.

## Configuration
- FF_SHIFT_ROTATE_EN:
  - Defined: all right and left shifts (manual and serialiser) rotate. MSB receives the old Q[0] on right shifts; LSB receives the old Q[WIDTH-1] on left shifts. sin_r and sin_l are ignored. After serialisation, Q equals the original D.
  - Undefined: fill uses sin_r and sin_l as above. After serialisation, Q holds the WIDTH sampled sin_r bits.

## Test plan
- Reset with RESET_VAL = 8'hA5, reset low mid-cycle -> Q = A5 and Qbar = 5A immediately; busy = 0, done = 0.
- en = 1, mode = 11, D = 8'h3C, then mode = 01 with sin_r = 1 for two cycles -> Q goes 3C, 9E, CF; Qbar = ~Q every cycle; en = 0 holds CF.
- mode = 10, sin_l = 0, Q = 81 -> 02. With FF_SHIFT_ROTATE_EN defined, Q = 81 -> 03.
- start = 1, D = 8'hB4, sin_r = 0 -> sout sequence 0,0,1,0,1,1,0,1 over 8 busy cycles. Then done = 1 for one cycle and Q = 00; with FF_SHIFT_ROTATE_EN defined, Q = B4.
- start pulsed again during BUSY and mode = 11 with en = 1 -> ignored, sequence unchanged. start in the done cycle with D = 8'h0F -> new sequence begins next cycle.
- clr = 1 at busy cycle 3 -> Q = 00, busy = 0 next cycle, no done pulse. reset low at busy cycle 5 -> reset values, no done pulse.

Source files
------------

// File: rtl/ff_shift_reg_if.sv
// rtl/ff_shift_reg_if.sv - signal bundle for the ff_shift_reg universal register
//
// Purpose: groups the control, data and status signals of ff_shift_reg.
//   master modport: the user that drives controls and reads register state.
//   slave modport:  the ff_shift_reg instance itself.
// Signals:
//   clr          synchronous clear (also aborts serialisation)
//   en           clock enable for manual modes
//   mode[1:0]    00 hold, 01 shift right, 10 shift left, 11 parallel load
//   D[WIDTH]     parallel load / serialiser data
//   sin_r        fill bit entering at the MSB on right shifts
//   sin_l        fill bit entering at the LSB on left shifts
//   start        begin serialising D
//   Q[WIDTH]     register contents
//   Qbar[WIDTH]  bitwise complement of Q
//   sout         serial output (Q[0])
//   busy         serialiser active
//   done         one-cycle pulse after serialisation completes
interface ff_shift_reg_if #(
  parameter int WIDTH = 8
);
  logic             clr;
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] D;
  logic             sin_r;
  logic             sin_l;
  logic             start;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Qbar;
  logic             sout;
  logic             busy;
  logic             done;

  modport master (
    output clr, en, mode, D, sin_r, sin_l, start,
    input  Q, Qbar, sout, busy, done
  );

  modport slave (
    input  clr, en, mode, D, sin_r, sin_l, start,
    output Q, Qbar, sout, busy, done
  );
endinterface

// File: rtl/ff_shift_reg.sv
// rtl/ff_shift_reg.sv - WIDTH-bit universal shift register with LSB-first serialiser
//
// Purpose: per clock holds, shifts right, shifts left or parallel-loads; a
//   self-timed serialiser loads D on start and shifts it out LSB-first over
//   WIDTH cycles, reporting busy and a one-cycle done pulse.
// Parameters: WIDTH (2..64), RESET_VAL (Q value while reset is asserted).
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    ff_shift_reg_if slave modport (controls in, Q/Qbar/sout/busy/done out)
// Build option: define FF_SHIFT_ROTATE_EN to make every shift a rotate
//   (sin_r/sin_l ignored; Q returns to the original D after serialisation).
module ff_shift_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic           clk,
  input logic           reset,
  ff_shift_reg_if.slave bus
);

  localparam int               CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [WIDTH-1:0] q_r;
  logic [CW-1:0]    cnt;
  logic             done_r;
  logic             fill_r;
  logic             fill_l;
  logic [WIDTH-1:0] q_shr;
  logic [WIDTH-1:0] q_shl;

`ifdef FF_SHIFT_ROTATE_EN
  assign fill_r = q_r[0];
  assign fill_l = q_r[WIDTH-1];
`else
  assign fill_r = bus.sin_r;
  assign fill_l = bus.sin_l;
`endif

  assign q_shr = {fill_r, q_r[WIDTH-1:1]};
  assign q_shl = {q_r[WIDTH-2:0], fill_l};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_r    <= RESET_VAL;
      state  <= IDLE;
      cnt    <= '0;
      done_r <= 1'b0;
    end else if (bus.clr) begin
      // Abort without a done pulse.
      q_r    <= '0;
      state  <= IDLE;
      cnt    <= '0;
      done_r <= 1'b0;
    end else if (state == BUSY) begin
      // Every busy edge shifts, including the last one, so WIDTH shifts in all.
      q_r <= q_shr;
      if (cnt == LAST) begin
        state  <= IDLE;
        done_r <= 1'b1;
      end else begin
        cnt    <= cnt + CW'(1);
        done_r <= 1'b0;
      end
    end else if (bus.start) begin
      // Accepted in IDLE, including the done cycle of a previous word.
      q_r    <= bus.D;
      cnt    <= '0;
      state  <= BUSY;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (bus.en) begin
        case (bus.mode)
          2'b01:   q_r <= q_shr;
          2'b10:   q_r <= q_shl;
          2'b11:   q_r <= bus.D;
          default: q_r <= q_r;
        endcase
      end
    end
  end

  assign bus.Q    = q_r;
  assign bus.Qbar = ~q_r;
  assign bus.sout = q_r[0];
  assign bus.busy = (state == BUSY);
  assign bus.done = done_r;

endmodule

// File: tb/tb_ff_shift_reg.sv
// tb/tb_ff_shift_reg.sv - directed scoreboard bench for ff_shift_reg (WIDTH 8, RESET_VAL A5)
module tb_ff_shift_reg;
  localparam int W = 8;

`ifdef FF_SHIFT_ROTATE_EN
  localparam logic [W-1:0] R1 = 8'h1E, R2 = 8'h0F, L1 = 8'h03, FIN1 = 8'hB4;
`else
  localparam logic [W-1:0] R1 = 8'h9E, R2 = 8'hCF, L1 = 8'h02, FIN1 = 8'h00;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ff_shift_reg_if #(.WIDTH(W)) bus ();

  ff_shift_reg #(.WIDTH(W), .RESET_VAL(8'hA5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    string          tag;
    logic [W-1:0]   q;
    logic           sout;
    logic           busy;
    logic           done;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic [W-1:0] d1;
  logic [W-1:0] d2;
  logic [W-1:0] fin;

  // Expected Q after k serialiser shifts of d with the given fill bit.
  function automatic logic [W-1:0] ser_q(input logic [W-1:0] d, input int k, input logic fill);
    logic [2*W-1:0] w;
`ifdef FF_SHIFT_ROTATE_EN
    w = {d, d};
`else
    w = {{W{fill}}, d};
`endif
    return W'(w >> k);
  endfunction

  task automatic push(input string tag, input logic [W-1:0] q, input logic s,
                      input logic b, input logic d);
    exp_t e;
    e.tag = tag; e.q = q; e.sout = s; e.busy = b; e.done = d;
    sb.push_back(e);
  endtask

  task automatic cmp(input string tag, input string fld, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s: observed %h expected %h", tag, fld, obs, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      cmp(e.tag, "Q",    bus.Q,        e.q);
      cmp(e.tag, "Qbar", bus.Qbar,     ~e.q);
      cmp(e.tag, "sout", W'(bus.sout), W'(e.sout));
      cmp(e.tag, "busy", W'(bus.busy), W'(e.busy));
      cmp(e.tag, "done", W'(bus.done), W'(e.done));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    d1 = 8'hB4;
    d2 = 8'h0F;
    fin = FIN1;
    reset = 1'b1;
    bus.clr = 1'b0; bus.en = 1'b0; bus.mode = 2'b00; bus.D = '0;
    bus.sin_r = 1'b0; bus.sin_l = 1'b0; bus.start = 1'b0;

    // Asynchronous reset, checked before any clock edge.
    #2 reset = 1'b0;
    #1 push("reset", 8'hA5, 1'b1, 1'b0, 1'b0); check_out();
    @(negedge clk) reset = 1'b1;

    // Manual load, right shifts, hold.
    bus.en = 1'b1; bus.mode = 2'b11; bus.D = 8'h3C;
    push("load3C", 8'h3C, 1'b0, 1'b0, 1'b0); tick(); check_out();
    bus.mode = 2'b01; bus.sin_r = 1'b1;
    push("shr1", R1, R1[0], 1'b0, 1'b0); tick(); check_out();
    push("shr2", R2, R2[0], 1'b0, 1'b0); tick(); check_out();
    bus.en = 1'b0;
    push("hold", R2, R2[0], 1'b0, 1'b0); tick(); check_out();

    // Left shift from 81.
    bus.en = 1'b1; bus.mode = 2'b11; bus.D = 8'h81;
    push("load81", 8'h81, 1'b1, 1'b0, 1'b0); tick(); check_out();
    bus.mode = 2'b10; bus.sin_l = 1'b0;
    push("shl", L1, L1[0], 1'b0, 1'b0); tick(); check_out();

    // Serialise B4 with zero fill; spurious start/load during BUSY.
    bus.en = 1'b0; bus.mode = 2'b00; bus.D = d1; bus.sin_r = 1'b0; bus.start = 1'b1;
    push("ser1_0", d1, d1[0], 1'b1, 1'b0); tick(); check_out();
    bus.start = 1'b0;
    for (int k = 1; k < W; k++) begin
      if (k == 2) begin bus.start = 1'b1; bus.en = 1'b1; bus.mode = 2'b11; bus.D = 8'hFF; end
      if (k == 3) begin bus.start = 1'b0; bus.en = 1'b0; bus.mode = 2'b00; bus.D = d1; end
      push($sformatf("ser1_%0d", k), ser_q(d1, k, 1'b0), d1[k], 1'b1, 1'b0);
      tick(); check_out();
    end
    push("done1", fin, fin[0], 1'b0, 1'b1); tick(); check_out();

    // start in the done cycle: new word 0F with one fill, cleared at busy cycle 3.
    bus.start = 1'b1; bus.D = d2; bus.sin_r = 1'b1;
    push("ser2_0", d2, d2[0], 1'b1, 1'b0); tick(); check_out();
    bus.start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      push($sformatf("ser2_%0d", k), ser_q(d2, k, 1'b1), d2[k], 1'b1, 1'b0);
      tick(); check_out();
    end
    bus.clr = 1'b1;
    push("clr", 8'h00, 1'b0, 1'b0, 1'b0); tick(); check_out();
    bus.clr = 1'b0;
    push("post_clr", 8'h00, 1'b0, 1'b0, 1'b0); tick(); check_out();

    // Third word, interrupted by asynchronous reset at busy cycle 5.
    bus.start = 1'b1; bus.D = d1;
    push("ser3_0", d1, d1[0], 1'b1, 1'b0); tick(); check_out();
    bus.start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      push($sformatf("ser3_%0d", k), ser_q(d1, k, 1'b1), d1[k], 1'b1, 1'b0);
      tick(); check_out();
    end
    #2 reset = 1'b0;
    #1 push("async_rst", 8'hA5, 1'b1, 1'b0, 1'b0); check_out();
    @(negedge clk) reset = 1'b1;
    push("after_rst", 8'hA5, 1'b1, 1'b0, 1'b0); tick(); check_out();

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
